// File: rtl/reflet_int_source.sv
// Conditions the four external interrupt lines before they reach the interrupt controller.
// Each line is synchronised, optionally debounced, then passed on as a level or as a latched rising edge.
module reflet_int_source #(
  parameter int unsigned sync_stages = 2,
  parameter int unsigned debounce    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] irq_in,
  input  logic [3:0] edge_mode,
  input  logic       ack_valid,
  input  logic [1:0] ack_id,
  input  logic [3:0] ovf_clear,
  output logic [3:0] ext_int,
  output logic [3:0] pending,
  output logic [3:0] overflow
);

  logic [3:0] sync_q [sync_stages];
  logic [3:0] syn;
  logic [3:0] stab;
  logic [3:0] stab_d;
  logic [3:0] rise;
  logic [3:0] ack_hit;
  logic [3:0] pending_q;
  logic [3:0] overflow_q;

  // The synchroniser keeps running while the CPU is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < sync_stages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign syn = sync_q[sync_stages-1];

  generate
    if (debounce == 0) begin : g_no_debounce
      assign stab = syn;
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(debounce + 1);
      localparam logic [CW-1:0] LAST = CW'(debounce - 1);

      logic [CW-1:0] cnt [4];
      logic [3:0]    stab_q;

      // A new level is accepted on the D-th consecutive sample that differs from stab.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stab_q <= '0;
          for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (enable) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (syn[i] == stab_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              stab_q[i] <= syn[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end

      assign stab = stab_q;
    end
  endgenerate

  always_comb begin
    ack_hit = '0;
    if (ack_valid && enable) ack_hit[ack_id] = 1'b1;
  end

  assign rise = stab & ~stab_d;

  // A rise coinciding with an ack keeps the line pending: the new edge replaces the consumed one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_d     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else if (enable) begin
      stab_d     <= stab;
      pending_q  <= edge_mode & (rise | (pending_q & ~ack_hit));
      overflow_q <= (rise & pending_q & ~ack_hit) | (overflow_q & ~ovf_clear);
    end
  end

  assign ext_int  = (edge_mode & pending_q) | (~edge_mode & stab);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reflet_int_source.sv
// Directed bench for reflet_int_source: one instance without debounce, one with debounce=3.
module tb_reflet_int_source;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] irq_in = '0;
  logic [3:0] edge_mode = '0;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_id = '0;
  logic [3:0] ovf_clear = '0;

  logic [3:0] ext0, pend0, ovf0;
  logic [3:0] ext3, pend3, ovf3;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  reflet_int_source #(.sync_stages(2), .debounce(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .irq_in(irq_in), .edge_mode(edge_mode),
    .ack_valid(ack_valid), .ack_id(ack_id), .ovf_clear(ovf_clear),
    .ext_int(ext0), .pending(pend0), .overflow(ovf0)
  );

  reflet_int_source #(.sync_stages(2), .debounce(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .irq_in(irq_in), .edge_mode(edge_mode),
    .ack_valid(ack_valid), .ack_id(ack_id), .ovf_clear(ovf_clear),
    .ext_int(ext3), .pending(pend3), .overflow(ovf3)
  );

  typedef struct {
    logic [3:0] irq;
    logic [3:0] em;
    logic       av;
    logic [1:0] id;
    logic [3:0] oc;
    logic [3:0] ext;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] irq, input logic [3:0] em, input logic av,
                             input logic [1:0] id, input logic [3:0] oc, input logic [3:0] ext,
                             input logic [3:0] pend, input logic [3:0] ovf);
    vec_t r;
    r.irq = irq; r.em = em; r.av = av; r.id = id; r.oc = oc;
    r.ext = ext; r.pend = pend; r.ovf = ovf;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] i_irq, input logic [3:0] i_em, input logic i_av,
                      input logic [1:0] i_id, input logic [3:0] i_oc);
    irq_in = i_irq; edge_mode = i_em; ack_valid = i_av; ack_id = i_id; ovf_clear = i_oc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    // Edge latch + ack on line 0
    tbl.push_back(v(4'b0001, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0001, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0001, 4'b0001, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // Level mode on line 2, ack to a level line ignored
    tbl.push_back(v(4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 4'b0000, 1, 2, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // Line 3: latch, second rise while pending -> overflow
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b1000, 1, 1, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b1000));
    // Clear overflow, then rise coincident with ack on line 3
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b1000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 1, 3, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    // Overflow set and clear in the same cycle: set wins
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b1000, 4'b1000, 4'b1000, 4'b1000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b1000, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 1, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    // Mode switches while line 3 is high
    tbl.push_back(v(4'b1000, 4'b0000, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

    #12;
    reset = 1'b1;
    check("reset_ext", ext0, 4'b0000);
    check("reset_pend", pend0, 4'b0000);
    check("reset_ovf", ovf0, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].irq, tbl[i].em, tbl[i].av, tbl[i].id, tbl[i].oc);
      check($sformatf("row%0d_ext", i), ext0, tbl[i].ext);
      check($sformatf("row%0d_pend", i), pend0, tbl[i].pend);
      check($sformatf("row%0d_ovf", i), ovf0, tbl[i].ovf);
    end

    // Reset mid-operation with line 0 pending
    pulse_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0001, 0, 0, 4'b0000);
    check("midrst_pre_pend", pend0, 4'b0001);
    reset = 1'b0;
    #1;
    check("midrst_pend", pend0, 4'b0000);
    check("midrst_ext", ext0, 4'b0000);
    check("midrst_ovf", ovf0, 4'b0000);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(4'b0001, 4'b0001, 0, 0, 4'b0000);
      check($sformatf("midrst_after%0d_pend", i), pend0, 4'b0000);
    end

    // Debounce=3 on line 1, level mode
    pulse_reset();
    step(4'b0000, 4'b0000, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step((i < 2) ? 4'b0010 : 4'b0000, 4'b0000, 0, 0, 4'b0000);
      check($sformatf("glitch%0d_ext", i), ext3 & 4'b0010, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 4'b0000, 0, 0, 4'b0000);
      check($sformatf("deb%0d_ext", i), ext3 & 4'b0010, (i == 4) ? 4'b0010 : 4'b0000);
      if (i == 1) check("nodeb_ext", ext0 & 4'b0010, 4'b0010);
    end
    check("deb_pend", pend3, 4'b0000);
    check("deb_ovf", ovf3, 4'b0000);

    // Enable hold: edge on line 0 while disabled, acks ignored
    pulse_reset();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 4'b0001, (i == 3), 0, 4'b0000);
      check($sformatf("dis%0d_ext", i), ext0, 4'b0000);
      check($sformatf("dis%0d_pend", i), pend0, 4'b0000);
    end
    enable = 1'b1;
    step(4'b0001, 4'b0001, 0, 0, 4'b0000);
    check("en_pend", pend0, 4'b0001);
    check("en_ext", ext0, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
